// File: rtl/ahb2ram_slave_if.sv
// AHB-Lite bus bundle between an initiator (or interconnect) and the RAM responder.
interface ahb2ram_slave_if;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, hready, htrans, hsize, hburst, hwrite, haddr, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, hready, htrans, hsize, hburst, hwrite, haddr, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb2ram_slave.sv
// AHB-Lite responder fronting a single-port synchronous RAM (1-cycle read latency).
// Reads issue in the address cycle; a read behind a write data phase costs one wait.
module ahb2ram_slave #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 ahb_clock,
  input  logic                 resetn,
  ahb2ram_slave_if.slave       ahb,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [3:0]           ram_byteena,
  output logic [31:0]          ram_data,
  output logic                 ram_wren,
  output logic                 ram_rden,
  input  logic [31:0]          ram_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDP, S_RDP, S_RSTALL, S_ERR1, S_ERR2
  } state_t;

  state_t               r_state, w_next;
  logic [ADDR_BITS-3:0] r_addr;
  logic [3:0]           r_be;
  logic                 w_accept, w_illegal, w_load;
  logic [3:0]           w_lanes;
  logic                 w_unused;

  assign w_unused = ^ahb.hburst;
  assign ram_data = ahb.hwdata;
  assign w_accept = ahb.hsel & ahb.hready & ahb.htrans[1];

  assign w_illegal = ((ahb.haddr >> ADDR_BITS) != 32'd0)
                   | (ahb.hsize > 3'd2)
                   | ((ahb.hsize == 3'd1) & ahb.haddr[0])
                   | ((ahb.hsize == 3'd2) & (ahb.haddr[1:0] != 2'b00));

  always_comb begin
    case (ahb.hsize)
      3'd0:    w_lanes = 4'b0001 << ahb.haddr[1:0];
      3'd1:    w_lanes = ahb.haddr[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge ahb_clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_addr <= ahb.haddr[ADDR_BITS-1:2];
        r_be   <= w_lanes;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    ahb.hreadyout = 1'b1;
    ahb.hresp     = 1'b0;
    ahb.hrdata    = '0;
    ram_addr      = r_addr;
    ram_byteena   = r_be;
    ram_wren      = 1'b0;
    ram_rden      = 1'b0;

    case (r_state)
      S_WDP:    ram_wren = 1'b1;
      S_RDP:    ahb.hrdata = ram_q;
      S_RSTALL: begin ram_rden = 1'b1; ahb.hreadyout = 1'b0; end
      S_ERR1:   begin ahb.hreadyout = 1'b0; ahb.hresp = 1'b1; end
      S_ERR2:   ahb.hresp = 1'b1;
      default:  ;
    endcase

    // Stall states hold hreadyout low, so no address phase can complete in them.
    case (r_state)
      S_RSTALL: w_next = S_RDP;
      S_ERR1:   w_next = S_ERR2;
      default: begin
        if (!w_accept) begin
          w_next = S_IDLE;
        end else if (w_illegal) begin
          w_next = S_ERR1;
        end else begin
          w_load = 1'b1;
          if (ahb.hwrite) begin
            w_next = S_WDP;
          end else if (r_state == S_WDP) begin
            w_next = S_RSTALL;
          end else begin
            w_next      = S_RDP;
            ram_rden    = 1'b1;
            ram_addr    = ahb.haddr[ADDR_BITS-1:2];
            ram_byteena = w_lanes;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ahb2ram_slave.sv
// Pipelined AHB-Lite master with a byte-level reference memory checking ahb2ram_slave.
module tb_ahb2ram_slave;
  localparam int AB = 10;

  logic ahb_clock = 1'b0;
  logic resetn;
  always #5 ahb_clock = ~ahb_clock;

  ahb2ram_slave_if bus();
  assign bus.hready = bus.hreadyout;

  logic [AB-3:0] ram_addr;
  logic [3:0]    ram_byteena;
  logic [31:0]   ram_data, ram_q;
  logic          ram_wren, ram_rden;

  ahb2ram_slave #(.ADDR_BITS(AB)) dut (
    .ahb_clock  (ahb_clock),
    .resetn     (resetn),
    .ahb        (bus),
    .ram_addr   (ram_addr),
    .ram_byteena(ram_byteena),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_rden   (ram_rden),
    .ram_q      (ram_q)
  );

  // Synchronous RAM the DUT drives
  logic [31:0] mem [256];
  logic        mem_clr;
  always @(posedge ahb_clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else begin
      if (ram_wren)
        for (int b = 0; b < 4; b++)
          if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
      if (ram_rden) ram_q <= mem[ram_addr];
    end
  end

  typedef struct {
    int        kind;   // 0 idle/busy, 1 unselected, 2 real transfer
    bit        wr;
    bit [2:0]  sz;
    bit [31:0] addr;
    bit [31:0] wd;
    bit        seq;
  } txn_t;

  txn_t        q[$];
  bit [7:0]    ref_mem [1024];
  int          ncmp = 0, nfail = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(int kind, bit wr, int sz, int unsigned addr, int unsigned wd, bit seq);
    txn_t t;
    t.kind = kind; t.wr = wr; t.sz = 3'(sz); t.addr = addr; t.wd = wd; t.seq = seq;
    return t;
  endfunction

  function automatic bit legal(txn_t t);
    return (t.addr < 32'(1 << AB)) && (t.sz <= 3'd2) && ((t.addr % (32'd1 << t.sz)) == 0);
  endfunction

  function automatic bit is_lw(txn_t t);
    return t.kind == 2 && legal(t) && t.wr;
  endfunction

  function automatic logic [3:0] lanes(txn_t t);
    int nb = 1 << t.sz;
    return 4'(((1 << nb) - 1) << (t.addr % 4));
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    int base = int'(a & 32'h3FC);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_write(txn_t t);
    int nb = 1 << t.sz;
    for (int k = 0; k < nb; k++) begin
      int ba = int'(t.addr) + k;
      ref_mem[ba] = t.wd[8*(ba % 4) +: 8];
    end
  endtask

  task automatic drive_idle();
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hsize = 3'd0; bus.hburst = 3'd0;
    bus.hwrite = 1'b0; bus.haddr = 32'h0;
  endtask

  task automatic drive(txn_t t);
    bus.hsel   = (t.kind != 1);
    bus.htrans = (t.kind == 0) ? {1'b0, t.seq} : (t.seq ? 2'b11 : 2'b10);
    bus.hsize  = t.sz;
    bus.hburst = t.seq ? 3'b111 : 3'b000;
    bus.hwrite = t.wr;
    bus.haddr  = t.addr;
  endtask

  // Plays q as a pipelined master; entered and left at posedge+1.
  task automatic run_q();
    int   a = 0, d = -1, waits = 0, ew = 0;
    bit   rdy, eflag;
    txn_t ta, td;
    while (a < q.size() || d >= 0) begin
      if (a < q.size()) drive(q[a]); else drive_idle();
      bus.hwdata = (d >= 0 && q[d].wr) ? q[d].wd : 32'h0;
      @(negedge ahb_clock);
      rdy = bus.hreadyout;
      chk("no_dual_strobe", 32'(ram_wren & ram_rden), 32'h0);
      if (d >= 0) begin
        td    = q[d];
        eflag = (td.kind == 2) && !legal(td);
        if (is_lw(td) && rdy) begin
          chk("wr_strobe", 32'(ram_wren), 32'h1);
          chk("wr_addr", 32'(ram_addr), 32'(td.addr[AB-1:2]));
          chk("wr_be", 32'(ram_byteena), 32'(lanes(td)));
        end
        if (eflag) chk("err_no_wren", 32'(ram_wren), 32'h0);
        if (!rdy) begin
          waits++;
          chk("stall_resp", 32'(bus.hresp), 32'(eflag));
          if (waits > 4) begin
            nfail++;
            $display("FAIL timeout: hreadyout low %0d cycles, limit 4", waits);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
            $fatal(1, "bus hung");
          end
        end else begin
          chk("wait_states", 32'(waits), 32'(ew));
          chk("resp", 32'(bus.hresp), 32'(eflag));
          if (td.kind == 2 && legal(td) && !td.wr) begin
            chk("rdata", bus.hrdata, ref_word(td.addr));
            last_rdata = bus.hrdata;
          end else begin
            chk("rdata_zero", bus.hrdata, 32'h0);
          end
          if (is_lw(td)) ref_write(td);
        end
      end
      if (rdy && a < q.size() && q[a].kind == 2) begin
        ta = q[a];
        if (!legal(ta)) chk("illegal_no_rden", 32'(ram_rden), 32'h0);
        else if (!ta.wr && !(d >= 0 && is_lw(q[d]))) begin
          chk("rd_strobe", 32'(ram_rden), 32'h1);
          chk("rd_addr", 32'(ram_addr), 32'(ta.addr[AB-1:2]));
        end
      end
      @(posedge ahb_clock); #1;
      if (rdy) begin
        if (a < q.size()) begin
          ta = q[a];
          if (ta.kind == 2 && !legal(ta)) ew = 1;
          else if (ta.kind == 2 && !ta.wr && d >= 0 && is_lw(q[d])) ew = 1;
          else ew = 0;
          d = a; a++;
        end else begin
          d = -1;
        end
        waits = 0;
      end
    end
    q.delete();
    drive_idle();
    bus.hwdata = 32'h0;
  endtask

  initial begin
    txn_t t;
    resetn = 1'b0; mem_clr = 1'b1;
    drive_idle(); bus.hwdata = 32'h0;
    repeat (3) @(posedge ahb_clock);
    #1;
    chk("rst_hreadyout", 32'(bus.hreadyout), 32'h1);
    chk("rst_hresp", 32'(bus.hresp), 32'h0);
    chk("rst_hrdata", bus.hrdata, 32'h0);
    chk("rst_wren", 32'(ram_wren), 32'h0);
    chk("rst_rden", 32'(ram_rden), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_be", 32'(ram_byteena), 32'h0);
    mem_clr = 1'b0; resetn = 1'b1;
    @(posedge ahb_clock); #1;

    // word write then read back, zero waits
    q.push_back(mk(2, 1, 2, 32'h10, 32'hDEADBEEF, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    q.push_back(mk(2, 0, 2, 32'h10, 0, 0));
    run_q();
    chk("p1_data", last_rdata, 32'hDEADBEEF);

    // byte lanes assembled into a word
    for (int i = 0; i < 4; i++)
      q.push_back(mk(2, 1, 0, 32'h20 + i, (32'h11 * (i + 1)) << (8 * i), 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    q.push_back(mk(2, 0, 2, 32'h20, 0, 0));
    run_q();
    chk("p2_data", last_rdata, 32'h44332211);

    // read right behind a write: one stall cycle
    q.push_back(mk(2, 1, 2, 32'h34, 32'h12345678, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    q.push_back(mk(2, 1, 2, 32'h30, 32'h0BADF00D, 0));
    q.push_back(mk(2, 0, 2, 32'h34, 0, 0));
    run_q();
    chk("p3_data", last_rdata, 32'h12345678);

    // preload then INCR16 read burst
    for (int i = 0; i < 16; i++) q.push_back(mk(2, 1, 2, 32'h40 + 4*i, 32'h100 + i, i != 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) q.push_back(mk(2, 0, 2, 32'h40 + 4*i, 0, i != 0));
    run_q();
    chk("p4_last", last_rdata, 32'h10F);

    // out-of-range and misaligned, then a legal read
    q.push_back(mk(2, 0, 2, 32'h400, 0, 0));
    q.push_back(mk(2, 1, 2, 32'h02, 32'hFFFFFFFF, 0));
    q.push_back(mk(2, 0, 2, 32'h10, 0, 0));
    run_q();
    chk("p5_after_err", last_rdata, 32'hDEADBEEF);

    // reset asserted in a write data phase
    t = mk(2, 1, 2, 32'h10, 32'hCAFEF00D, 0);
    drive(t);
    @(posedge ahb_clock); #1;
    drive_idle(); bus.hwdata = 32'hCAFEF00D;
    #2;
    chk("rst_pre_wren", 32'(ram_wren), 32'h1);
    resetn = 1'b0;
    #1;
    chk("midrst_wren", 32'(ram_wren), 32'h0);
    chk("midrst_rden", 32'(ram_rden), 32'h0);
    chk("midrst_hreadyout", 32'(bus.hreadyout), 32'h1);
    chk("midrst_hresp", 32'(bus.hresp), 32'h0);
    chk("midrst_addr", 32'(ram_addr), 32'h0);
    @(posedge ahb_clock); #1;
    chk("midrst_nocommit", mem[4], ref_word(32'h10));
    resetn = 1'b1;
    bus.hwdata = 32'h0;
    q.push_back(mk(2, 0, 2, 32'h10, 0, 0));
    run_q();
    chk("midrst_readback", last_rdata, 32'hDEADBEEF);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      int r = int'($urandom_range(0, 19));
      t.kind = (r == 0) ? 0 : (r == 1) ? 1 : 2;
      t.wr   = 1'($urandom_range(0, 1));
      t.sz   = 3'($urandom_range(0, 2));
      t.addr = $urandom_range(0, 127) & ~((32'd1 << t.sz) - 1);
      t.wd   = $urandom;
      t.seq  = 1'($urandom_range(0, 1));
      if (r == 2) t.sz = 3'($urandom_range(3, 7));
      if (r == 3) t.addr = t.addr | (32'h400 << $urandom_range(0, 21));
      if (r == 4) begin t.sz = 3'($urandom_range(1, 2)); t.addr = t.addr | 32'h1; end
      q.push_back(t);
    end
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ahb2ram_slave.md
# ahb2ram_slave

AHB-Lite responder that exposes a single-port synchronous RAM (1-cycle read latency, no output register) to an AHB initiator. It is the slave-side counterpart to our RAM-to-AHB DMA initiators: it lets a master reach on-chip buffer RAM as memory-mapped space. Handles byte/halfword/word transfers, all incrementing bursts, and single-port read-after-write collisions by inserting a wait state. Reports out-of-range and illegal transfers with a two-cycle ERROR response.

## Interface

- ADDR_BITS, 10, byte-address width of the RAM window; RAM holds 2^(ADDR_BITS-2) words.
- ahb_clock  in  1  clock, all logic rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- ahb_hsel  in  1  slave select.
- ahb_hready  in  1  bus HREADY from interconnect; qualifies address phases.
- ahb_htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- ahb_hsize  in  3  000 byte, 001 half, 010 word; others illegal.
- ahb_hburst  in  3  ignored; addresses are taken per beat.
- ahb_hwrite  in  1  1 = write.
- ahb_haddr  in  32  byte address.
- ahb_hwdata  in  32  write data, valid in write data phase.
- ahb_hreadyout  out  1  slave ready; reset 1.
- ahb_hresp  out  1  0 OKAY, 1 ERROR; reset 0.
- ahb_hrdata  out  32  read data; equals ram_q during read data phase, 0 otherwise.
- ram_addr  out  ADDR_BITS-2  word address; reset 0.
- ram_byteena  out  4  byte lanes; reset 0.
- ram_data  out  32  write data (ahb_hwdata pass-through).
- ram_wren  out  1  write strobe; reset 0.
- ram_rden  out  1  read strobe; reset 0.
- ram_q  in  32  read data, valid 1 cycle after ram_rden.

## Operation

- Accept = hsel && hready && htrans[1]. On accept, register haddr, hsize, hwrite into address-phase regs. IDLE/BUSY or !hsel: no RAM access, OKAY zero-wait.
- Legality: illegal if haddr[31:ADDR_BITS] != 0, hsize > 010, half with haddr[0]=1, or word with haddr[1:0]!=0.
- Byte lanes: byte -> 1<<haddr[1:0]; half -> 0011 or 1100 by haddr[1]; word -> 1111.
- FSM states:
  - IDLE.
  - WDP (write data phase): ram_wren=1, ram_addr/ram_byteena from registered phase, ram_data=hwdata; hreadyout=1.
  - RDP (read data phase): hrdata=ram_q, hreadyout=1.
  - RSTALL: read was accepted during WDP; ram_rden issued this cycle, hreadyout=0, then -> RDP.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Read accept while port free (IDLE or RDP): ram_rden=1 combinationally in the address cycle, ram_addr=haddr[ADDR_BITS-1:2]; next state RDP.
- Read accept during WDP: RAM port busy with the write. Latch read address; next state RSTALL.
- Write accept: next state WDP from IDLE, RDP or WDP. Back-to-back writes are zero-wait.
- Illegal accept: next state ERR1 -> ERR2; no RAM strobe. A transfer presented during ERR2 (hready=1) is accepted normally. Any transfer presented during ERR1 is ignored, since hready=0.
- On hreadyout=1 with no accept: -> IDLE.
- ram_wren and ram_rden are never both 1 in the same cycle.

## Timing

- Read latency: 0 wait states normally; 1 wait state only when the read address phase overlaps a write data phase.
- Write: 0 wait states; RAM written in the data-phase cycle.
- ERROR: exactly 2 data-phase cycles (hreadyout 0 then 1, hresp high both).
- hrdata is not registered; ram_q passes through combinationally in RDP.
- Reset mid-transfer: all FSM regs -> IDLE immediately, hreadyout=1, strobes 0. A write in progress is not committed.
- ahb_hsel dropping in a data phase does not abort that data phase.

## Test plan

- Word write 0xDEADBEEF @0x10, then read @0x10 -> ram_wren at word 4 byteena 1111; read returns 0xDEADBEEF with no hreadyout low.
- Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, then word read -> byteena 0001,0010,0100,1000; read returns 0x44332211.
- Write @0x30 followed directly by NONSEQ read @0x34 -> one cycle hreadyout=0 (RSTALL); ram_rden only after ram_wren; data correct.
- INCR16 read burst from 0x40 after preload -> 16 beats, zero waits, ram_addr 16..31 consecutive.
- Read @0x400 (ADDR_BITS=10) and word at 0x02 -> each gives hresp 1/1 with hreadyout 0 then 1; no RAM strobes; the next legal transfer is OKAY.
- Assert resetn low during a WDP -> outputs at reset values within the same cycle; ram_wren=0; the target word is unchanged.
